// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter: round-robin arbiter for 4 cores feeding the cache
// controller; latches winner op/address and holds the bus until done.
// Ports: clk, reset (async, active-low), req/req_op/req_addr (per core),
//   done (completion pulse) -> gnt, which_core_requesting, bus_valid,
//   bus_op, bus_addr (line aligned), busy, timeout_err.
// Option: define ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles.
module coherence_bus_arbiter #(
   parameter int NUM_CORES      = 4,
   parameter int ADDR_W         = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [2*NUM_CORES-1:0]      req_op,
   input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
   input  logic                        done,
   output logic [NUM_CORES-1:0]        gnt,
   output logic [1:0]                  which_core_requesting,
   output logic                        bus_valid,
   output logic [1:0]                  bus_op,
   output logic [ADDR_W-1:0]           bus_addr,
   output logic                        busy,
   output logic                        timeout_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]        state;
   logic [1:0]        rr_ptr;
   logic [1:0]        win;
   logic [ADDR_W-1:0] win_addr;
   logic [1:0]        win_op;
   logic              finish;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       expire;
   assign expire = (state == S_WAIT) && !done &&
                   (wait_cnt == 8'(TIMEOUT_CYCLES));
`endif

   // Scan from the farthest offset down so the offset nearest rr_ptr wins.
   always_comb begin
      win = rr_ptr;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (req[rr_ptr + 2'(k)]) win = rr_ptr + 2'(k);
      end
   end

   assign win_op   = req_op[{win, 1'b0} +: 2];
   assign win_addr = req_addr[win * ADDR_W +: ADDR_W];

   // done during ISSUE or WAIT closes the transaction; done in IDLE is ignored.
`ifdef ARB_TIMEOUT_EN
   assign finish = ((state == S_ISSUE) || (state == S_WAIT)) && (done || expire);
`else
   assign finish = ((state == S_ISSUE) || (state == S_WAIT)) && done;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                 <= S_IDLE;
         rr_ptr                <= 2'd0;
         gnt                   <= '0;
         which_core_requesting <= 2'd0;
         bus_valid             <= 1'b0;
         bus_op                <= 2'd0;
         bus_addr              <= '0;
         busy                  <= 1'b0;
         timeout_err           <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         wait_cnt              <= 8'd0;
`endif
      end else begin
         bus_valid   <= 1'b0;
         timeout_err <= 1'b0;
         if (finish) begin
            state  <= S_IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= which_core_requesting + 2'd1;
`ifdef ARB_TIMEOUT_EN
            timeout_err <= expire;
`endif
         end else begin
            unique case (state)
               S_IDLE: begin
                  gnt <= '0;
                  if (|req) begin
                     state                 <= S_ISSUE;
                     gnt                   <= NUM_CORES'(1) << win;
                     which_core_requesting <= win;
                     bus_op                <= win_op;
                     bus_addr              <= {win_addr[ADDR_W-1:4], 4'b0};
                     busy                  <= 1'b1;
                     bus_valid             <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                     wait_cnt              <= 8'd0;
`endif
                  end
               end
               S_ISSUE: state <= S_WAIT;
               S_WAIT: begin
`ifdef ARB_TIMEOUT_EN
                  wait_cnt <= wait_cnt + 8'd1;
`endif
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Scoreboard bench for coherence_bus_arbiter: a round-robin model predicts
// each grant; predictions are queued at request time and popped on bus_valid.
module tb_coherence_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [7:0]  req_op;
   logic [47:0] req_addr;
   logic        done;
   logic [3:0]  gnt;
   logic [1:0]  which;
   logic        bus_valid;
   logic [1:0]  bus_op;
   logic [11:0] bus_addr;
   logic        busy;
   logic        timeout_err;

   typedef struct {
      int         id;
      logic [1:0] op;
      logic [11:0] addr;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   rr = 0;

   coherence_bus_arbiter dut (
      .clk                   (clk),
      .reset                 (rst_n),
      .req                   (req),
      .req_op                (req_op),
      .req_addr              (req_addr),
      .done                  (done),
      .gnt                   (gnt),
      .which_core_requesting (which),
      .bus_valid             (bus_valid),
      .bus_op                (bus_op),
      .bus_addr              (bus_addr),
      .busy                  (busy),
      .timeout_err           (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic exp_t predict(input logic [3:0] r, input logic [7:0] ops,
                                    input logic [47:0] addrs, input int p);
      exp_t e;
      e.id   = pick(r, p);
      e.op   = ops[e.id*2 +: 2];
      e.addr = addrs[e.id*12 +: 12] & 12'hFF0;
      return e;
   endfunction

   // Monitor: every bus_valid strobe is one transaction on the bus.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus_valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("sb_unexpected", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("sb_gnt", gnt, 32'(1) << mon_e.id);
            chk("sb_which", which, mon_e.id);
            chk("sb_op", bus_op, mon_e.op);
            chk("sb_addr", bus_addr, mon_e.addr);
            chk("sb_busy", busy, 1);
         end
      end
   end

   // Starts and ends on a negedge. d = number of WAIT cycles before done.
   task automatic txn(input logic [3:0] r, input logic [7:0] ops,
                      input logic [47:0] addrs, input int d, input bit hold);
      exp_t e;
      int   to;
      req      = r;
      req_op   = ops;
      req_addr = addrs;
      e = predict(r, ops, addrs, rr);
      q.push_back(e);
      to = 0;
      do begin
         @(negedge clk);
         to++;
      end while (bus_valid !== 1'b1 && to < 10);
      if (bus_valid !== 1'b1) begin
         chk("grant_timeout", 0, 1);
         req = 4'b0;
         return;
      end
      if (!hold) req = 4'b0;
      if (d == 0) begin
         done = 1'b1;
      end else begin
         for (int i = 0; i < d; i++) begin
            req_op   = 8'($urandom);
            req_addr = {$urandom, $urandom};
            @(negedge clk);
            chk("wait_valid", bus_valid, 0);
            chk("wait_gnt", gnt, 32'(1) << e.id);
            chk("wait_addr", bus_addr, e.addr);
            chk("wait_op", bus_op, e.op);
            chk("wait_tmo", timeout_err, 0);
         end
         done = 1'b1;
      end
      @(negedge clk);
      done = 1'b0;
      chk("cpl_gnt", gnt, 0);
      chk("cpl_busy", busy, 0);
      chk("cpl_valid", bus_valid, 0);
      rr = (e.id + 1) % 4;
   endtask

   initial begin
      rst_n    = 1'b0;
      req      = 4'b0;
      req_op   = 8'b0;
      req_addr = 48'b0;
      done     = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_which", which, 0);
      chk("rst_valid", bus_valid, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tmo", timeout_err, 0);
      rst_n = 1'b1;

      // single request from core 1: op 01, addr 0x3A7 -> 0x3A0, rr -> 2
      txn(4'b0010, 8'b0000_0100, 48'h000_000_3A7_000, 3, 0);

      // reset in the middle of a WAIT with core 2 granted
      req = 4'b0100;
      q.push_back(predict(4'b0100, 8'hB4, 48'h000_5A5_000_000, rr));
      req_op   = 8'hB4;
      req_addr = 48'h000_5A5_000_000;
      repeat (3) @(negedge clk);
      req = 4'b0;
      chk("t1_pre_gnt", gnt, 4'b0100);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_gnt", gnt, 0);
      chk("t1_which", which, 0);
      chk("t1_valid", bus_valid, 0);
      chk("t1_op", bus_op, 0);
      chk("t1_addr", bus_addr, 0);
      chk("t1_busy", busy, 0);
      rr = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // all four held: expect 0,1,2,3,0
      for (int i = 0; i < 5; i++)
         txn(4'b1111, 8'hE4, 48'h400_300_200_100, 2, 1);
      req = 4'b0;

      // wrap: reach rr=3, then 1001 -> core 3, then core 0, then rr=1
      txn(4'b0100, 8'h00, 48'h000_123_000_000, 1, 0);
      txn(4'b1001, 8'hC3, 48'hFFF_000_000_00F, 1, 0);
      txn(4'b1001, 8'hC3, 48'hFFF_000_000_00F, 1, 0);
      txn(4'b0011, 8'h09, 48'h000_000_AB1_CD2, 1, 0);

      // fast done in ISSUE
      txn(4'b0100, 8'h20, 48'h000_7FF_000_000, 0, 0);
      txn(4'b1000, 8'h80, 48'h86C_000_000_000, 0, 0);

      // done in IDLE with no request
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_done_gnt", gnt, 0);
      chk("idle_done_busy", busy, 0);
      chk("idle_done_valid", bus_valid, 0);

      // random traffic
      for (int i = 0; i < 30; i++) begin
         logic [3:0] r;
         r = 4'($urandom_range(1, 15));
         txn(r, 8'($urandom), {$urandom, $urandom}, $urandom_range(0, 4),
             1'($urandom_range(0, 1)));
         req = 4'b0;
      end

      repeat (3) @(negedge clk);
      chk("sb_drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
